lcm_reg_bank: RTL and testbench
===============================

// Module: lcm_reg_bank
// PURPOSE
//  Parametrised LCM register bank. Decodes software register writes into a flat array of
//  NUM_REGS x DATA_W control registers with byte enables and per-register self-clearing pulse
//  mode, plus a registered read-back path. Sits between the LCM command parser and the
//  SSM/PGM/sender datapath. Replaces fixed per-register decode with generic indexed storage.
// PARAMETERS
//  NUM_REGS   16        number of register slots (addr 0 is read-only ID)
//  DATA_W     64        register width, multiple of 8
//  ADDR_W     8         width of wr_addr/rd_addr
//  PULSE_MASK 16'h00A4  bit i=1: register i self-clears after PULSE_LEN cycles
//  PULSE_LEN  1         hold cycles for pulse registers, 1..255
//  LMID       8'd31     module ID returned in ID register
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  async reset, active-low
//  wr_valid       in   1                  write request
//  wr_ready       out  1                  write accept
//  wr_addr        in   ADDR_W             write register index
//  wr_data        in   DATA_W             write data
//  wr_be          in   DATA_W/8           byte enables, bit b covers wr_data[8b+7:8b]
//  wr_err         out  1                  1-cycle pulse: write to addr 0 or addr>=NUM_REGS
//  rd_valid       in   1                  read request (always accepted)
//  rd_addr        in   ADDR_W             read register index
//  rd_data_valid  out  1                  read response strobe
//  rd_data        out  DATA_W             read response data
//  rd_err         out  1                  read response to addr>=NUM_REGS, with rd_data_valid
//  reg_flat       out  NUM_REGS*DATA_W    register i on [i*DATA_W +: DATA_W]
//  reg_upd        out  NUM_REGS           1-cycle strobe, register i just written
// BEHAVIOUR
//  Clock/reset: one clock clk; rst_n asynchronous, active-low.
//  Reset: all outputs 0; all registers, pulse counters and read pipeline 0; wr_ready=0.
//  wr_ready: registered; 0 in reset, 1 from first clk edge after rst_n deassert.
//  Write: accepted at edge T when wr_valid&&wr_ready. For 1<=wr_addr<NUM_REGS:
//   byte b of reg[wr_addr] <= wr_data byte b iff wr_be[b]; other bytes hold.
//   New value is visible on reg_flat and reg_upd[wr_addr]=1 for exactly the cycle after T.
//   wr_be=0 still pulses reg_upd; the value is unchanged.
//  Illegal write (addr 0 or >=NUM_REGS): no state change, wr_err=1 for one cycle after T.
//  Pulse registers (PULSE_MASK[i]=1): on write, counter[i] <= PULSE_LEN; value held for
//   PULSE_LEN cycles after T, then the whole register clears to 0 (no reg_upd on clear).
//   A write while counter[i]!=0 merges bytes into the current value and reloads the counter
//   (retrigger). Level registers hold their value until rewritten or reset.
//  ID register (addr 0): reads {zeros, NUM_REGS[7:0], LMID}; bits[7:0]=LMID.
//  Read: latency 1. rd_valid at edge T -> rd_data_valid=1 in cycle T+1 with rd_data equal to
//   the register value before edge T (a same-edge write is not visible). Out of range:
//   rd_data=0, rd_err=1. Back-to-back reads give one response per cycle. Without rd_valid,
//   rd_data_valid=0 and rd_data holds its last value.
//  Simultaneous read and write, any addresses: both complete independently.
//  Pulse clear coincident with a write to the same register: the write wins and the counter
//   reloads.
//  Reset mid-operation: counters and registers clear; any in-flight response is dropped.
//  Width rules: an address is compared at full ADDR_W width, with no truncation to
//   log2(NUM_REGS) bits.
// TESTING
//  Reset, read addr 0 -> rd_data=64'h0000_0000_0000_101F at T+1, rd_err=0.
//  Write addr 4 data 64'h1122334455667788 be=8'h0F, then read 4 -> 64'h0000000055667788;
//   reg_upd[4] pulses once.
//  Write pulse reg 7 value 1 (PULSE_LEN=1) -> reg7=1 for exactly one cycle, then 0.
//   Rewrite in that cycle -> stays 1 one more cycle.
//  Write addr 0 and addr 20 -> wr_err pulses twice, reg_flat unchanged. Read addr 20 ->
//   rd_err=1, rd_data=0.
//  Same-cycle write 64'hAA and read of addr 3 (old value 64'h55) -> rd_data=64'h55;
//   the next read returns 64'hAA.
//  Assert rst_n low while reg7 pulse is active and reg 3 is set -> all 0 at once,
//   wr_ready=0 until the first edge after release.

Source files
------------

// File: rtl/lcm_reg_bank.sv
// lcm_reg_bank: indexed LCM control register bank with byte-enable writes, pulse registers and registered read-back
module lcm_reg_bank #(
   parameter int                  NUM_REGS   = 16,
   parameter int                  DATA_W     = 64,
   parameter int                  ADDR_W     = 8,
   parameter logic [NUM_REGS-1:0] PULSE_MASK = 16'h00A4,
   parameter int                  PULSE_LEN  = 1,
   parameter logic [7:0]          LMID       = 8'd31
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic [DATA_W/8-1:0]          wr_be,
   output logic                         wr_err,
   input  logic                         rd_valid,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic                         rd_data_valid,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_err,
   output logic [NUM_REGS*DATA_W-1:0]   reg_flat,
   output logic [NUM_REGS-1:0]          reg_upd
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [DATA_W-1:0] ID_VAL = DATA_W'({8'(NUM_REGS), LMID});

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [7:0]          cnt_q  [NUM_REGS];
   logic [7:0]          cnt_d  [NUM_REGS];
   logic                wr_ready_q, wr_err_q, wr_err_d;
   logic [NUM_REGS-1:0] reg_upd_q, reg_upd_d;
   logic                rd_data_valid_q, rd_data_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_err_q, rd_err_d;
   logic                wr_acc, wr_sel, wr_hit, rd_hit;
   logic [DATA_W-1:0]   wr_mask, rd_sel;

   // Address decode, byte merge, pulse countdown and read-back selection; addresses compare at full width
   always_comb begin
      wr_acc    = wr_valid && wr_ready_q;
      wr_mask   = '0;
      wr_sel    = 1'b0;
      wr_hit    = 1'b0;
      rd_hit    = 1'b0;
      rd_sel    = '0;
      reg_upd_d = '0;
      for (int b = 0; b < BE_W; b++)
         wr_mask[8*b +: 8] = {8{wr_be[b]}};
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i]    = regs_q[i];
         cnt_d[i]     = cnt_q[i];
         wr_sel       = wr_acc && (i != 0) && (wr_addr == ADDR_W'(i));
         reg_upd_d[i] = wr_sel;
         wr_hit       = wr_hit | wr_sel;
         if (wr_sel) begin
            regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
            cnt_d[i]  = PULSE_MASK[i] ? 8'(PULSE_LEN) : 8'd0;
         end else if (cnt_q[i] != 8'd0) begin
            cnt_d[i]  = cnt_q[i] - 8'd1;
            regs_d[i] = (cnt_q[i] == 8'd1) ? '0 : regs_q[i];
         end
         if (rd_addr == ADDR_W'(i)) begin
            rd_hit = 1'b1;
            rd_sel = (i == 0) ? ID_VAL : regs_q[i];
         end
      end
      wr_err_d        = wr_acc && !wr_hit;
      rd_data_valid_d = rd_valid;
      rd_err_d        = rd_valid && !rd_hit;
      rd_data_d       = rd_valid ? rd_sel : rd_data_q;
   end

   // State registers; reset clears storage, counters and any in-flight read response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         wr_ready_q      <= 1'b0;
         wr_err_q        <= 1'b0;
         reg_upd_q       <= '0;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= '0;
         rd_err_q        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         wr_ready_q      <= 1'b1;
         wr_err_q        <= wr_err_d;
         reg_upd_q       <= reg_upd_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_q       <= rd_data_d;
         rd_err_q        <= rd_err_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign wr_ready      = wr_ready_q;
   assign wr_err        = wr_err_q;
   assign reg_upd       = reg_upd_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_data       = rd_data_q;
   assign rd_err        = rd_err_q;
endmodule

// File: tb/tb_lcm_reg_bank.sv
// tb_lcm_reg_bank: directed and random stimulus against a cycle-level reference model of the register bank
module tb_lcm_reg_bank;
   localparam int          N  = 16;
   localparam int          DW = 64;
   localparam int          AW = 8;
   localparam int          BW = 8;
   localparam logic [15:0] PM = 16'h00A4;
   localparam int          PL = 1;
   localparam logic [63:0] ID = 64'h0000_0000_0000_101F;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            wr_valid = 1'b0, rd_valid = 1'b0;
   logic [AW-1:0]   wr_addr = '0, rd_addr = '0;
   logic [DW-1:0]   wr_data = '0;
   logic [BW-1:0]   wr_be = '0;
   logic            wr_ready, wr_err, rd_data_valid, rd_err;
   logic [DW-1:0]   rd_data;
   logic [N*DW-1:0] reg_flat;
   logic [N-1:0]    reg_upd;

   int              n_chk = 0, n_fail = 0, cyc = 0;
   logic [63:0]     m_reg [N];
   int              m_exp [N];
   logic            m_ready, e_rd_valid, e_rd_err, e_wr_err;
   logic [63:0]     e_rd_data;
   logic [N-1:0]    e_upd;

   lcm_reg_bank dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .wr_err(wr_err),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data_valid(rd_data_valid),
      .rd_data(rd_data), .rd_err(rd_err),
      .reg_flat(reg_flat), .reg_upd(reg_upd)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      check("wr_ready", 64'(wr_ready), 64'(m_ready));
      check("wr_err", 64'(wr_err), 64'(e_wr_err));
      check("reg_upd", 64'(reg_upd), 64'(e_upd));
      check("rd_data_valid", 64'(rd_data_valid), 64'(e_rd_valid));
      check("rd_err", 64'(rd_err), 64'(e_rd_err));
      check("rd_data", rd_data, e_rd_data);
      for (int i = 1; i < N; i++)
         check($sformatf("reg%0d", i), reg_flat[i*DW +: DW], m_reg[i]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_reg[i] = '0;
         m_exp[i] = -1;
      end
      m_ready = 0; e_rd_valid = 0; e_rd_err = 0; e_wr_err = 0; e_rd_data = '0; e_upd = '0;
   endtask

   // One clock edge of the specified behaviour, using the inputs presented at that edge
   task automatic model_edge();
      logic acc;
      cyc++;
      acc = wr_valid && m_ready;
      e_rd_valid = rd_valid;
      e_rd_err = 0;
      if (rd_valid) begin
         if (rd_addr == 0) e_rd_data = ID;
         else if (rd_addr < N) e_rd_data = m_reg[int'(rd_addr)];
         else begin
            e_rd_data = '0;
            e_rd_err = 1;
         end
      end
      e_wr_err = acc && (wr_addr == 0 || wr_addr >= N);
      e_upd = '0;
      for (int i = 1; i < N; i++) begin
         if (acc && wr_addr == i) begin
            for (int b = 0; b < BW; b++)
               if (wr_be[b]) m_reg[i][8*b +: 8] = wr_data[8*b +: 8];
            e_upd[i] = 1'b1;
            if (PM[i]) m_exp[i] = cyc + PL;
         end else if (m_exp[i] == cyc) begin
            m_reg[i] = '0;
            m_exp[i] = -1;
         end
      end
      m_ready = 1;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic op(input logic wv, input logic [7:0] wa, input logic [63:0] wd, input logic [7:0] be,
                     input logic rv, input logic [7:0] ra);
      wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_valid = rv; rd_addr = ra;
      step();
      wr_valid = 0; rd_valid = 0;
   endtask

   // Reset asserted mid-cycle: everything must clear immediately, wr_ready rises only at the first edge after release
   task automatic do_reset();
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1;
      check("ready_before_edge", 64'(wr_ready), 64'd0);
      step();
      check("ready_after_edge", 64'(wr_ready), 64'd1);
   endtask

   initial begin
      model_reset();
      do_reset();
      op(0, 0, 0, 0, 1, 0);
      check("id_read", rd_data, 64'h0000_0000_0000_101F);
      check("id_err", 64'(rd_err), 64'd0);
      op(1, 4, 64'h1122334455667788, 8'h0F, 0, 0);
      check("upd4_set", 64'(reg_upd[4]), 64'd1);
      op(0, 0, 0, 0, 1, 4);
      check("upd4_once", 64'(reg_upd[4]), 64'd0);
      op(0, 0, 0, 0, 0, 0);
      check("rd4", rd_data, 64'h0000000055667788);
      op(1, 7, 64'd1, 8'hFF, 0, 0);
      check("pulse_on", reg_flat[7*DW +: DW], 64'd1);
      op(0, 0, 0, 0, 0, 0);
      check("pulse_off", reg_flat[7*DW +: DW], 64'd0);
      op(1, 7, 64'd1, 8'hFF, 0, 0);
      op(1, 7, 64'd1, 8'hFF, 0, 0);
      check("retrig_on", reg_flat[7*DW +: DW], 64'd1);
      op(0, 0, 0, 0, 0, 0);
      check("retrig_off", reg_flat[7*DW +: DW], 64'd0);
      op(1, 0, 64'hDEAD, 8'hFF, 0, 0);
      check("err_addr0", 64'(wr_err), 64'd1);
      op(1, 20, 64'hBEEF, 8'hFF, 0, 0);
      check("err_addr20", 64'(wr_err), 64'd1);
      op(0, 0, 0, 0, 1, 20);
      check("err_clear", 64'(wr_err), 64'd0);
      check("rd20_err", 64'(rd_err), 64'd1);
      check("rd20_data", rd_data, 64'd0);
      op(1, 3, 64'h55, 8'hFF, 0, 0);
      op(1, 3, 64'hAA, 8'hFF, 1, 3);
      check("rw_old", rd_data, 64'h55);
      op(0, 0, 0, 0, 1, 3);
      check("rw_new", rd_data, 64'hAA);
      op(1, 7, 64'h77, 8'hFF, 1, 3);
      check("pre_rst_reg7", reg_flat[7*DW +: DW], 64'h77);
      do_reset();
      for (int k = 0; k < 600; k++) begin
         op(1'($urandom), 8'($urandom_range(0, 20)), {$urandom, $urandom}, 8'($urandom),
            1'($urandom), 8'($urandom_range(0, 20)));
         if (k == 300) do_reset();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
